// File: rtl/password_entry_ctrl.sv
// password_entry_ctrl
// Front-end for the password authenticator. It shifts hex keypad digits into a password word,
// raises enter_btn as a held request once a full word is submitted, and reads led_success,
// led_fail and led_locked as the response. It drops enter_btn to complete the handshake, waits a
// short guard time for lock status to settle, and then accepts a new entry.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   key_valid     1-cycle strobe, key_code holds a new digit
//   key_code      hex digit
//   key_clear     1-cycle strobe, discard the digits entered so far
//   key_enter     1-cycle strobe, submit the word
//   led_success   authenticator grant (level)
//   led_fail      authenticator deny (level)
//   led_locked    authenticator lockout (level)
//   password_out  assembled password word (PW_W = 4*DIGITS bits)
//   enter_btn     held request to the authenticator
//   digit_count   number of digits held
//   busy          high in every state except entry
//   result_ok     1-cycle pulse, grant seen
//   result_fail   1-cycle pulse, deny seen
//   timeout_err   1-cycle pulse, no response within RESP_TIMEOUT cycles
//   fail_count    saturating count of consecutive denials, cleared by a grant
//   locked        sticky lockout flag, cleared only by rst
//
// Build option PW_SCRUB_EN: when defined, password_out is zeroed as the response wait ends (for
// any cause) and on lockout. When undefined, password_out keeps its last value and new digits
// shift into it.

module password_entry_ctrl #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned RESP_TIMEOUT = 64,
  parameter int unsigned GUARD_CYCLES = 2,
  localparam int unsigned PwW         = 4 * DIGITS,
  localparam int unsigned CntW        = $clog2(DIGITS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_valid,
  input  logic [3:0]      key_code,
  input  logic            key_clear,
  input  logic            key_enter,
  input  logic            led_success,
  input  logic            led_fail,
  input  logic            led_locked,
  output logic [PwW-1:0]  password_out,
  output logic            enter_btn,
  output logic [CntW-1:0] digit_count,
  output logic            busy,
  output logic            result_ok,
  output logic            result_fail,
  output logic            timeout_err,
  output logic [1:0]      fail_count,
  output logic            locked
);

  localparam int unsigned TmrW = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned GrdW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  typedef enum logic [1:0] {StEntry, StWaitResp, StRelease, StLocked} state_e;

  state_e          state_q, state_d;
  logic [PwW-1:0]  pw_q, pw_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [GrdW-1:0] guard_q, guard_d;
  logic [1:0]      fail_cnt_q, fail_cnt_d;
  logic            locked_q, locked_d;
  logic            ok_q, ok_d;
  logic            fail_q, fail_d;
  logic            tmo_q, tmo_d;
  logic            exit_wait;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEntry;
      pw_q       <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      guard_q    <= '0;
      fail_cnt_q <= '0;
      locked_q   <= 1'b0;
      ok_q       <= 1'b0;
      fail_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pw_q       <= pw_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      guard_q    <= guard_d;
      fail_cnt_q <= fail_cnt_d;
      locked_q   <= locked_d;
      ok_q       <= ok_d;
      fail_q     <= fail_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pw_d       = pw_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    guard_d    = guard_q;
    fail_cnt_d = fail_cnt_q;
    locked_d   = locked_q;
    ok_d       = 1'b0;
    fail_d     = 1'b0;
    tmo_d      = 1'b0;
    exit_wait  = 1'b0;

    // Lockout overrides whatever handshake is in flight.
    if (led_locked && (state_q != StLocked)) begin
      state_d  = StLocked;
      locked_d = 1'b1;
`ifdef PW_SCRUB_EN
      pw_d     = '0;
`endif
    end else begin
      unique case (state_q)
        StEntry: begin
          if (key_clear) begin
            pw_d  = '0;
            cnt_d = '0;
          end else if (key_valid && (cnt_q < CntW'(DIGITS))) begin
            pw_d  = {pw_q[PwW-5:0], key_code};
            cnt_d = cnt_q + 1'b1;
          end else if (key_enter && (cnt_q == CntW'(DIGITS))) begin
            state_d = StWaitResp;
            timer_d = '0;
          end
        end
        StWaitResp: begin
          if (led_success) begin
            ok_d       = 1'b1;
            fail_cnt_d = '0;
            exit_wait  = 1'b1;
          end else if (led_fail) begin
            fail_d     = 1'b1;
            fail_cnt_d = (fail_cnt_q == 2'd3) ? 2'd3 : fail_cnt_q + 2'd1;
            exit_wait  = 1'b1;
          end else if (timer_q == TmrW'(RESP_TIMEOUT)) begin
            tmo_d     = 1'b1;
            exit_wait = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
          if (exit_wait) begin
            state_d = StRelease;
            cnt_d   = '0;
            guard_d = '0;
`ifdef PW_SCRUB_EN
            pw_d    = '0;
`endif
          end
        end
        StRelease: begin
          // Key strobes are dropped here; only the guard timer advances.
          if (guard_q == GrdW'(GUARD_CYCLES - 1)) begin
            state_d = StEntry;
          end else begin
            guard_d = guard_q + 1'b1;
          end
        end
        StLocked: begin
          state_d = StLocked;
        end
        default: begin
          state_d = StEntry;
        end
      endcase
    end
  end

  // enter_btn decodes straight from state so an asynchronous reset drops it immediately.
  assign enter_btn    = (state_q == StWaitResp);
  assign busy         = (state_q != StEntry);
  assign password_out = pw_q;
  assign digit_count  = cnt_q;
  assign result_ok    = ok_q;
  assign result_fail  = fail_q;
  assign timeout_err  = tmo_q;
  assign fail_count   = fail_cnt_q;
  assign locked       = locked_q;

endmodule
